// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: IF/ID/EXE/MEM/WB/HALT sequencer with Moore strobe decode.
// Optional memory wait states are enabled by defining MEM_WAIT_EN.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        Reset,
  input  logic [15:0] Ins,
  input  logic        Z,
  input  logic        C,
  input  logic        MemRdy,
  output logic        MemReq,
  output logic        MemWE,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        WBRF,
  output logic        WBresource,
  output logic        RBresource,
  output logic        OprandB,
  output logic        LI,
  output logic        Buff_IDEXE,
  output logic [2:0]  ALUop,
  output logic        UseCarry,
  output logic        Flag,
  output logic        Halted,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_ADC  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_SBB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_CMP  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_LI   = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ST   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_JCC  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_op;
  logic       w_rdy;
  logic       w_cond;
  logic       w_unused;

  logic       w_mem_req, w_mem_we, w_ir_write, w_pc_write, w_pc_src, w_wbrf;
  logic       w_wb_res, w_rb_res, w_opr_b, w_li, w_buff, w_use_carry, w_flag, w_halted;
  logic [2:0] w_alu_op;

  assign w_op   = Ins[15:12];
  assign w_cond = Ins[11] ? C : Z;

`ifdef MEM_WAIT_EN
  assign w_rdy    = MemRdy;
  assign w_unused = ^Ins[10:0];
`else
  assign w_rdy    = 1'b1;
  assign w_unused = ^{MemRdy, Ins[10:0]};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (Reset) r_state <= S_IF;
    else       r_state <= w_next;
  end

  // Next-state and Moore strobe decode
  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_pc_src    = 1'b0;
    w_wbrf      = 1'b0;
    w_wb_res    = 1'b0;
    w_rb_res    = 1'b0;
    w_opr_b     = 1'b0;
    w_li        = 1'b0;
    w_buff      = 1'b0;
    w_alu_op    = 3'd0;
    w_use_carry = 1'b0;
    w_flag      = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      S_IF: begin
        w_mem_req  = 1'b1;
        w_ir_write = w_rdy;
        w_pc_write = w_rdy;
        if (w_rdy) w_next = S_ID;
      end
      S_ID: begin
        w_buff = 1'b1;
        case (w_op)
          OP_NOP:  w_next = S_IF;
          OP_HALT: w_next = S_HALT;
          default: w_next = S_EXE;
        endcase
      end
      S_EXE: begin
        case (w_op)
          OP_SUB, OP_SBB, OP_CMP: w_alu_op = 3'd1;
          OP_AND:                 w_alu_op = 3'd2;
          OP_OR:                  w_alu_op = 3'd3;
          OP_XOR:                 w_alu_op = 3'd4;
          OP_MOV, OP_LI:          w_alu_op = 3'd5;
          default:                w_alu_op = 3'd0;
        endcase
        w_use_carry = (w_op == OP_ADC) || (w_op == OP_SBB);
        w_flag      = (w_op >= OP_ADD) && (w_op <= OP_CMP);
        w_opr_b     = (w_op == OP_LI) || (w_op == OP_LD) || (w_op == OP_ST);
        w_li        = w_opr_b;
        case (w_op)
          OP_CMP:       w_next = S_IF;
          OP_LD, OP_ST: w_next = S_MEM;
          OP_JMP: begin
            w_next     = S_IF;
            w_pc_write = 1'b1;
            w_pc_src   = 1'b1;
          end
          OP_JCC: begin
            w_next     = S_IF;
            w_pc_write = w_cond;
            w_pc_src   = w_cond;
          end
          default:      w_next = S_WB;
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (w_op == OP_ST);
        w_rb_res  = (w_op == OP_ST);
        if (w_rdy) w_next = (w_op == OP_LD) ? S_WB : S_IF;
      end
      S_WB: begin
        w_wbrf   = 1'b1;
        w_wb_res = (w_op == OP_LD);
        w_next   = S_IF;
      end
      S_HALT: w_halted = 1'b1;
      default: w_next = S_IF;
    endcase
  end

  // Reset masks every strobe so nothing leaks out while the sequencer is held
  assign MemReq     = w_mem_req   & ~Reset;
  assign MemWE      = w_mem_we    & ~Reset;
  assign IRWrite    = w_ir_write  & ~Reset;
  assign PCWrite    = w_pc_write  & ~Reset;
  assign PCSrc      = w_pc_src    & ~Reset;
  assign WBRF       = w_wbrf      & ~Reset;
  assign WBresource = w_wb_res    & ~Reset;
  assign RBresource = w_rb_res    & ~Reset;
  assign OprandB    = w_opr_b     & ~Reset;
  assign LI         = w_li        & ~Reset;
  assign Buff_IDEXE = w_buff      & ~Reset;
  assign UseCarry   = w_use_carry & ~Reset;
  assign Flag       = w_flag      & ~Reset;
  assign Halted     = w_halted    & ~Reset;
  assign ALUop      = Reset ? 3'd0 : w_alu_op;
  assign State      = Reset ? 3'd0 : 3'(r_state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, corner sequences, randomized instructions.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req, mem_we, ir_write, pc_write, pc_src, wbrf;
    logic       wb_res, rb_res, opr_b, li, buff;
    logic [2:0] alu_op;
    logic       use_carry, flag, halted;
    logic [2:0] state;
  } out_t;

  typedef struct {
    logic [15:0] ins;
    logic        z;
    logic        c;
    int          cycles;
    logic        taken;
  } vec_t;

  logic        clk = 1'b0;
  logic        Reset, Z, C, MemRdy;
  logic [15:0] Ins;
  logic        MemReq, MemWE, IRWrite, PCWrite, PCSrc, WBRF, WBresource, RBresource;
  logic        OprandB, LI, Buff_IDEXE, UseCarry, Flag, Halted;
  logic [2:0]  ALUop, State;
  out_t        act;

  int n_cmp = 0;
  int n_bad = 0;
  int path[$];
  vec_t tab[19];

  multicycle_ctrl dut (
    .clk(clk), .Reset(Reset), .Ins(Ins), .Z(Z), .C(C), .MemRdy(MemRdy),
    .MemReq(MemReq), .MemWE(MemWE), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .WBRF(WBRF), .WBresource(WBresource), .RBresource(RBresource), .OprandB(OprandB),
    .LI(LI), .Buff_IDEXE(Buff_IDEXE), .ALUop(ALUop), .UseCarry(UseCarry), .Flag(Flag),
    .Halted(Halted), .State(State)
  );

  always #5 clk = ~clk;

  assign act = {MemReq, MemWE, IRWrite, PCWrite, PCSrc, WBRF, WBresource, RBresource,
                OprandB, LI, Buff_IDEXE, ALUop, UseCarry, Flag, Halted, State};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [2:0] alu_of(input logic [3:0] op);
    case (op)
      4'h3, 4'h4, 4'h8: return 3'd1;
      4'h5:             return 3'd2;
      4'h6:             return 3'd3;
      4'h7:             return 3'd4;
      4'h9, 4'hA:       return 3'd5;
      default:          return 3'd0;
    endcase
  endfunction

  // Phase codes: 0 IF, 1 ID, 2 EXE, 3 MEM, 4 WB, 5 HALT
  function automatic out_t exp_out(input int ph, input logic [15:0] ins,
                                   input logic z, input logic c, input logic rdy_in);
    out_t e;
    logic [3:0] op;
    logic rdy;
    e  = '0;
    op = ins[15:12];
    rdy = rdy_in;
`ifndef MEM_WAIT_EN
    rdy = 1'b1;
`endif
    e.state = 3'(ph);
    case (ph)
      0: begin e.mem_req = 1'b1; e.ir_write = rdy; e.pc_write = rdy; end
      1: e.buff = 1'b1;
      2: begin
        e.alu_op    = alu_of(op);
        e.use_carry = (op == 4'h2) || (op == 4'h4);
        e.flag      = (op >= 4'h1) && (op <= 4'h8);
        e.opr_b     = (op >= 4'hA) && (op <= 4'hC);
        e.li        = e.opr_b;
        if (op == 4'hD) begin e.pc_write = 1'b1; e.pc_src = 1'b1; end
        if (op == 4'hE) begin e.pc_write = ins[11] ? c : z; e.pc_src = e.pc_write; end
      end
      3: begin e.mem_req = 1'b1; e.mem_we = (op == 4'hC); e.rb_res = (op == 4'hC); end
      4: begin e.wbrf = 1'b1; e.wb_res = (op == 4'hB); end
      5: e.halted = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic void build_path(input logic [15:0] ins);
    logic [3:0] op;
    op = ins[15:12];
    path.delete();
    path.push_back(0);
    path.push_back(1);
    if (op == 4'hF) path.push_back(5);
    else if (op != 4'h0) begin
      path.push_back(2);
      if (op == 4'hB) begin path.push_back(3); path.push_back(4); end
      else if (op == 4'hC) path.push_back(3);
      else if (op < 4'h8 || op == 4'h9 || op == 4'hA) path.push_back(4);
    end
  endfunction

  function automatic int model_cycles(input logic [15:0] ins);
    case (ins[15:12])
      4'h0:             return 2;
      4'h8, 4'hD, 4'hE: return 3;
      4'hB:             return 5;
      default:          return 4;
    endcase
  endfunction

  function automatic logic model_taken(input logic [15:0] ins, input logic z, input logic c);
    if (ins[15:12] == 4'hD) return 1'b1;
    if (ins[15:12] == 4'hE) return ins[11] ? c : z;
    return 1'b0;
  endfunction

  task automatic check(input string nm, input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (state %0d)", nm, act, exp, State);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic drive_rdy();
`ifdef MEM_WAIT_EN
    MemRdy = 1'b1;
`else
    MemRdy = 1'($urandom);
`endif
  endtask

  // Entered just after an IF cycle has become visible; leaves at the next IF cycle.
  task automatic run_instr(input logic [15:0] ins, input logic z, input logic c,
                           input int exp_cyc, input logic exp_taken, input string nm);
    int   cyc;
    logic taken;
    Ins = ins; Z = z; C = c;
    build_path(ins);
    cyc = 0; taken = 1'b0;
    #1 check({nm, " IF"}, exp_out(0, ins, z, c, MemRdy));
    for (int k = 1; k < 8; k++) begin
      @(negedge clk); drive_rdy(); #1;
      if (State == 3'd0) begin cyc = k; break; end
      if (k < path.size()) check(nm, exp_out(path[k], ins, z, c, MemRdy));
      if (State == 3'd2 && PCWrite) taken = 1'b1;
    end
    if (cyc == 0) cyc = 8;
    check_int({nm, " cycles"}, cyc, exp_cyc);
    check_int({nm, " taken"}, int'(taken), int'(exp_taken));
  endtask

  task automatic step_check(input int ph, input string nm);
    @(negedge clk); #1;
    check(nm, exp_out(ph, Ins, Z, C, MemRdy));
  endtask

  initial begin
    tab[0]  = '{16'h0000, 1'b0, 1'b0, 2, 1'b0};
    tab[1]  = '{16'h1234, 1'b0, 1'b0, 4, 1'b0};
    tab[2]  = '{16'h2000, 1'b0, 1'b1, 4, 1'b0};
    tab[3]  = '{16'h3000, 1'b1, 1'b0, 4, 1'b0};
    tab[4]  = '{16'h4000, 1'b0, 1'b0, 4, 1'b0};
    tab[5]  = '{16'h5000, 1'b0, 1'b0, 4, 1'b0};
    tab[6]  = '{16'h6000, 1'b0, 1'b0, 4, 1'b0};
    tab[7]  = '{16'h7000, 1'b0, 1'b0, 4, 1'b0};
    tab[8]  = '{16'h8000, 1'b1, 1'b1, 3, 1'b0};
    tab[9]  = '{16'h9000, 1'b0, 1'b0, 4, 1'b0};
    tab[10] = '{16'hA0FF, 1'b0, 1'b0, 4, 1'b0};
    tab[11] = '{16'hB000, 1'b0, 1'b0, 5, 1'b0};
    tab[12] = '{16'hC000, 1'b0, 1'b0, 4, 1'b0};
    tab[13] = '{16'hD000, 1'b0, 1'b0, 3, 1'b1};
    tab[14] = '{16'hE000, 1'b1, 1'b0, 3, 1'b1};
    tab[15] = '{16'hE000, 1'b0, 1'b0, 3, 1'b0};
    tab[16] = '{16'hE800, 1'b0, 1'b1, 3, 1'b1};
    tab[17] = '{16'hE800, 1'b1, 1'b0, 3, 1'b0};
    tab[18] = '{16'hE000, 1'b0, 1'b1, 3, 1'b0};

    Reset = 1'b1; Ins = 16'h1000; Z = 1'b0; C = 1'b0; MemRdy = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      check("reset outputs", '0);
    end
    Reset = 1'b0;
    #1 check("first IF after reset", exp_out(0, Ins, Z, C, MemRdy));

    foreach (tab[i])
      run_instr(tab[i].ins, tab[i].z, tab[i].c, tab[i].cycles, tab[i].taken,
                $sformatf("vec%0d", i));

    // HALT holds until Reset, then resumes from IF
    Ins = 16'hF000;
    #1 check("halt IF", exp_out(0, Ins, Z, C, MemRdy));
    step_check(1, "halt ID");
    for (int i = 0; i < 10; i++) step_check(5, "halt hold");
    @(negedge clk); Reset = 1'b1; #1;
    check("halt reset outputs", '0);
    @(negedge clk); Reset = 1'b0; Ins = 16'h0000; #1;
    check("halt exit IF", exp_out(0, Ins, Z, C, MemRdy));

    // Reset during the MEM cycle of LD must abort before writeback
    Ins = 16'hB000;
    #1 check("ldrst IF", exp_out(0, Ins, Z, C, MemRdy));
    step_check(1, "ldrst ID");
    step_check(2, "ldrst EXE");
    step_check(3, "ldrst MEM");
    Reset = 1'b1; #1;
    check("ldrst reset outputs", '0);
    @(negedge clk); Reset = 1'b0; Ins = 16'h0000; #1;
    check("ldrst IF after reset", exp_out(0, Ins, Z, C, MemRdy));
    run_instr(16'h0000, 1'b0, 1'b0, 2, 1'b0, "ldrst nop");

`ifdef MEM_WAIT_EN
    // ST with three wait cycles in MEM
    Ins = 16'hC000; MemRdy = 1'b1;
    #1 check("stwait IF", exp_out(0, Ins, Z, C, MemRdy));
    step_check(1, "stwait ID");
    step_check(2, "stwait EXE");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); MemRdy = (i == 3); #1;
      check("stwait MEM", exp_out(3, Ins, Z, C, MemRdy));
    end
    @(negedge clk); MemRdy = 1'b1; #1;
    check("stwait IF after MEM", exp_out(0, Ins, Z, C, MemRdy));
`endif

    for (int n = 0; n < 300; n++) begin
      logic [15:0] ins;
      logic        z, c;
      ins = {4'($urandom_range(0, 14)), 12'($urandom)};
      z   = 1'($urandom);
      c   = 1'($urandom);
      run_instr(ins, z, c, model_cycles(ins), model_taken(ins, z, c), $sformatf("rand%h", ins));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
